noc_vc_fifo: RTL

Multi-virtual-channel synchronous input buffer for a NoC router port. It holds NUM_VC independent FIFOs in one partitioned storage array. Each FIFO has its own pointers, occupancy count, full/empty/almost-full flags and sticky error flags. Reads are first-word-fall-through, so the router switch allocator can inspect head flits with zero latency.

---
 rtl/noc_vc_fifo_pkg.sv | 23 ++
 rtl/noc_vc_fifo_ctrl.sv | 106 ++++++++++
 rtl/noc_vc_fifo.sv | 119 +++++++++++
 3 files changed

// File: rtl/noc_vc_fifo_pkg.sv
// ---------------------------------------------------------------------------
// noc_vc_fifo_pkg
// Shared defaults for the multi-VC input buffer and the router-level
// instances that use it. These are the flit width, pointer width, depth per
// VC, number of VCs, VC index width and almost-full threshold. The package
// also provides a helper that gives the width of one per-VC count slice.
// ---------------------------------------------------------------------------
package noc_vc_fifo_pkg;

  localparam int NOC_DATA_WIDTH   = 12;
  localparam int NOC_ADDR_WIDTH   = 3;
  localparam int NOC_RAM_DEPTH    = 8;
  localparam int NOC_NUM_VC       = 4;
  localparam int NOC_VC_WIDTH     = 2;
  localparam int NOC_AFULL_THRESH = 6;

  // A count needs one bit more than a pointer, so a VC can report that it
  // holds exactly RAM_DEPTH entries.
  function automatic int cntWidth(input int addrWidth);
    return addrWidth + 1;
  endfunction

endpackage

// File: rtl/noc_vc_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// noc_vc_ctrl
// Bookkeeping for a single virtual channel: read/write pointers, occupancy
// count, the full/empty/almost-full flags and the sticky error flags.
// The storage array itself lives in the parent.
//
// Ports
//   clk, rst          clock and synchronous active-high reset
//   wr_req_i          a write addressed to this VC (accepted or not)
//   rd_req_i          a read addressed to this VC (accepted or not)
//   wr_acc_i          the write to this VC is accepted this cycle
//   rd_acc_i          the read from this VC is accepted this cycle
//   err_clr_i         clears the sticky error flags
//   wr_ptr_o          next storage slot to write
//   rd_ptr_o          slot holding the head flit
//   count_o           occupancy, 0..RAM_DEPTH
//   full_o, empty_o, almost_full_o   decoded from the registered count
//   overflow_o        sticky: a write was rejected because the VC was full
//   underflow_o       sticky: a read was rejected because the VC was empty
// ---------------------------------------------------------------------------
module noc_vc_ctrl
  import noc_vc_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH   = NOC_ADDR_WIDTH,
  parameter int RAM_DEPTH    = NOC_RAM_DEPTH,
  parameter int AFULL_THRESH = NOC_AFULL_THRESH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_req_i,
  input  logic                  rd_req_i,
  input  logic                  wr_acc_i,
  input  logic                  rd_acc_i,
  input  logic                  err_clr_i,
  output logic [ADDR_WIDTH-1:0] wr_ptr_o,
  output logic [ADDR_WIDTH-1:0] rd_ptr_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_C = (ADDR_WIDTH+1)'(AFULL_THRESH);

  logic [ADDR_WIDTH-1:0] wrPtr_q, wrPtr_d;
  logic [ADDR_WIDTH-1:0] rdPtr_q, rdPtr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  // Next-state logic. The pointers wrap naturally because RAM_DEPTH is a
  // power of two. A simultaneous accepted read and write leaves the count
  // unchanged. A request that is rejected sets its error flag. That set
  // takes priority over err_clr in the same cycle, so an error is never lost.
  always_comb begin
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_acc_i) wrPtr_d = wrPtr_q + 1'b1;
    if (rd_acc_i) rdPtr_d = rdPtr_q + 1'b1;

    if (wr_acc_i && !rd_acc_i)      count_d = count_q + 1'b1;
    else if (rd_acc_i && !wr_acc_i) count_d = count_q - 1'b1;

    if (err_clr_i) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (wr_req_i && !wr_acc_i) overflow_d  = 1'b1;
    if (rd_req_i && !rd_acc_i) underflow_d = 1'b1;
  end

  // State register. Reset returns the VC to empty and ignores any request
  // that is present in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign wr_ptr_o      = wrPtr_q;
  assign rd_ptr_o      = rdPtr_q;
  assign count_o       = count_q;
  assign full_o        = (count_q == DEPTH_C);
  assign empty_o       = (count_q == '0);
  assign almost_full_o = (count_q >= AFULL_C);
  assign overflow_o    = overflow_q;
  assign underflow_o   = underflow_q;

endmodule

// File: rtl/noc_vc_fifo.sv
// ---------------------------------------------------------------------------
// noc_vc_fifo
// Multi-virtual-channel input buffer for one NoC router port. NUM_VC
// independent FIFOs share one partitioned storage array. Reads are
// first-word-fall-through: data_out always shows the head flit of rd_vc.
//
// Ports
//   clk, rst       clock and synchronous active-high reset
//   wr_en, wr_vc, data_in   write request, target VC and flit
//   rd_en, rd_vc   pop request and the VC presented on data_out
//   data_out       head flit of rd_vc (combinational from storage)
//   full, empty, almost_full   per-VC flags, bit i = VC i
//   count          per-VC occupancy, VC i in [i*(ADDR_WIDTH+1) +: ADDR_WIDTH+1]
//   overflow, underflow        per-VC sticky error flags
//   err_clr        clears all sticky error flags on the next edge
// ---------------------------------------------------------------------------
module noc_vc_fifo
  import noc_vc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = NOC_DATA_WIDTH,
  parameter int ADDR_WIDTH   = NOC_ADDR_WIDTH,
  parameter int RAM_DEPTH    = NOC_RAM_DEPTH,
  parameter int NUM_VC       = NOC_NUM_VC,
  parameter int VC_WIDTH     = NOC_VC_WIDTH,
  parameter int AFULL_THRESH = NOC_AFULL_THRESH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                wr_en,
  input  logic [VC_WIDTH-1:0]                 wr_vc,
  input  logic [DATA_WIDTH-1:0]               data_in,
  input  logic                                rd_en,
  input  logic [VC_WIDTH-1:0]                 rd_vc,
  output logic [DATA_WIDTH-1:0]               data_out,
  output logic [NUM_VC-1:0]                   full,
  output logic [NUM_VC-1:0]                   empty,
  output logic [NUM_VC-1:0]                   almost_full,
  output logic [NUM_VC*(ADDR_WIDTH+1)-1:0]    count,
  output logic [NUM_VC-1:0]                   overflow,
  output logic [NUM_VC-1:0]                   underflow,
  input  logic                                err_clr
);

  localparam int CW = cntWidth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [NUM_VC*RAM_DEPTH];

  logic [NUM_VC-1:0]     wrReq, rdReq, wrAcc, rdAcc;
  logic [ADDR_WIDTH-1:0] wrPtr [NUM_VC];
  logic [ADDR_WIDTH-1:0] rdPtr [NUM_VC];
  logic [CW-1:0]         vcCount [NUM_VC];

  logic                  wrVcValid, rdVcValid;
  logic [ADDR_WIDTH-1:0] wrPtrSel, rdPtrSel;

  // A VC index beyond NUM_VC matches no channel. Such a request is dropped
  // silently and raises no error flag.
  assign wrVcValid = ({1'b0, wr_vc} < (VC_WIDTH+1)'(NUM_VC));
  assign rdVcValid = ({1'b0, rd_vc} < (VC_WIDTH+1)'(NUM_VC));

  for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
    // Acceptance is decoded from the pre-edge flags. A full VC therefore
    // rejects a write even when a read from it is accepted in the same cycle.
    assign wrReq[i] = wr_en && (wr_vc == VC_WIDTH'(i));
    assign rdReq[i] = rd_en && (rd_vc == VC_WIDTH'(i));
    assign wrAcc[i] = wrReq[i] && !full[i];
    assign rdAcc[i] = rdReq[i] && !empty[i];

    noc_vc_ctrl #(
      .ADDR_WIDTH   (ADDR_WIDTH),
      .RAM_DEPTH    (RAM_DEPTH),
      .AFULL_THRESH (AFULL_THRESH)
    ) u_ctrl (
      .clk           (clk),
      .rst           (rst),
      .wr_req_i      (wrReq[i]),
      .rd_req_i      (rdReq[i]),
      .wr_acc_i      (wrAcc[i]),
      .rd_acc_i      (rdAcc[i]),
      .err_clr_i     (err_clr),
      .wr_ptr_o      (wrPtr[i]),
      .rd_ptr_o      (rdPtr[i]),
      .count_o       (vcCount[i]),
      .full_o        (full[i]),
      .empty_o       (empty[i]),
      .almost_full_o (almost_full[i]),
      .overflow_o    (overflow[i]),
      .underflow_o   (underflow[i])
    );

    assign count[i*CW +: CW] = vcCount[i];
  end

  // Pointer selection for the single write port and the single read port.
  // An out-of-range VC selects slot 0 and is masked further down.
  always_comb begin
    wrPtrSel = '0;
    rdPtrSel = '0;
    if (wrVcValid) wrPtrSel = wrPtr[wr_vc];
    if (rdVcValid) rdPtrSel = rdPtr[rd_vc];
  end

  // Storage write. The VC index forms the upper address bits, so each VC
  // owns a contiguous block of RAM_DEPTH slots. Storage is never reset, and
  // a write that arrives in a reset cycle is discarded.
  always_ff @(posedge clk) begin
    if (!rst && (|wrAcc)) begin
      mem_q[{wr_vc, wrPtrSel}] <= data_in;
    end
  end

  // First-word-fall-through read. The head slot of rd_vc drives data_out
  // directly, so the flit is visible in the same cycle as rd_en.
  always_comb begin
    data_out = '0;
    if (rdVcValid) data_out = mem_q[{rd_vc, rdPtrSel}];
  end

endmodule
